// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Adapts LSU byte/half/word loads and stores to a word-only
//                memory: lane extraction, sign/zero extension, sub-word RMW.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter bit FAULT_ON_UNSELECTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rw,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_selected
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_WRITE    = 3'd3,
        S_FAULT    = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign w_misaligned = (req_size == 2'b11) ||
                          ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_byte      = mem_read_data[{r_lane, 3'b000} +: 8];
        w_half      = mem_read_data[{r_lane[1], 4'b0000} +: 16];
        w_load_data = mem_read_data;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = mem_read_data;
        endcase
    end

    // Only the addressed lane is replaced; the rest comes from the read word.
    always_comb begin
        w_merge = mem_read_data;
        if (r_size == 2'b00)
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= 16'h0000;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_fault     <= 1'b0;
            resp_rdata     <= 32'h0000_0000;
            mem_rw         <= 1'b0;
            mem_address    <= 32'h0000_0000;
            mem_write_data <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_lane      <= req_addr[1:0];
                        r_wdata     <= req_wdata[15:0];
                        mem_address <= {req_addr[31:2], 2'b00};
                        if (w_misaligned) begin
                            // Fault reply is presented in the FAULT cycle itself.
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0000_0000;
                            r_state    <= S_FAULT;
                        end else if (!req_we) begin
                            r_state <= S_LOAD;
                        end else if (req_size == 2'b10) begin
                            mem_write_data <= req_wdata;
                            mem_rw         <= 1'b1;
                            r_state        <= S_WRITE;
                        end else begin
                            r_state <= S_RMW_READ;
                        end
                    end
                end
                S_LOAD: begin
                    resp_valid <= 1'b1;
                    resp_fault <= FAULT_ON_UNSELECTED & ~mem_selected;
                    resp_rdata <= mem_selected ? w_load_data : 32'h0000_0000;
                    r_state    <= S_RESP;
                end
                S_RMW_READ: begin
                    if (mem_selected) begin
                        mem_write_data <= w_merge;
                        mem_rw         <= 1'b1;
                        r_state        <= S_WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_fault <= FAULT_ON_UNSELECTED;
                        resp_rdata <= 32'h0000_0000;
                        r_state    <= S_RESP;
                    end
                end
                S_WRITE: begin
                    mem_rw     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_fault <= FAULT_ON_UNSELECTED & ~mem_selected;
                    resp_rdata <= 32'h0000_0000;
                    r_state    <= S_RESP;
                end
                S_FAULT, S_RESP: begin
                    resp_valid  <= 1'b0;
                    resp_fault  <= 1'b0;
                    resp_rdata  <= 32'h0000_0000;
                    mem_address <= 32'h0000_0000;
                    req_ready   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    mem_rw    <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed bench for mem_access_unit with a word-array memory
//                and a spec-level reference model of responses and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        req_ready, resp_valid, resp_fault, mem_rw, mem_selected;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        req_ready0, resp_valid0, resp_fault0, mem_rw0, mem_selected0;
    logic [31:0] resp_rdata0, mem_address0, mem_write_data0, mem_read_data0;

    always #5 clk = ~clk;

    mem_access_unit #(.FAULT_ON_UNSELECTED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_rw(mem_rw),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_selected(mem_selected)
    );

    mem_access_unit #(.FAULT_ON_UNSELECTED(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
        .resp_rdata(resp_rdata0), .resp_fault(resp_fault0), .mem_rw(mem_rw0),
        .mem_address(mem_address0), .mem_write_data(mem_write_data0),
        .mem_read_data(mem_read_data0), .mem_selected(mem_selected0)
    );

    // Physical memory written only by the FAULT_ON_UNSELECTED=1 instance.
    logic [31:0] mem       [0:255];
    logic [31:0] model_mem [0:255];

    assign mem_selected   = (mem_address[31:20] == 12'h800);
    assign mem_read_data  = mem[mem_address[9:2]];
    assign mem_selected0  = (mem_address0[31:20] == 12'h800);
    assign mem_read_data0 = mem[mem_address0[9:2]];

    always @(posedge clk)
        if (mem_rw && mem_selected) mem[mem_address[9:2]] <= mem_write_data;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          exp_at = 0;
    bit          pending = 1'b0;
    bit          chk_on = 1'b0;
    logic [31:0] exp_rdata, exp_maddr, last_rdata;
    logic        exp_fault, exp_fault0, last_fault;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        if (chk_on) begin
            ev = pending && (cyc == exp_at);
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
            chk("resp_valid_nf", {31'd0, resp_valid0}, {31'd0, ev});
            chk("mem_rw_nf", {31'd0, mem_rw0}, {31'd0, mem_rw});
            if (mem_rw) begin
                wr_cnt++;
                chk("write_addr", mem_address, exp_maddr);
            end
            if (ev) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_fault", {31'd0, resp_fault}, {31'd0, exp_fault});
                chk("resp_rdata_nf", resp_rdata0, exp_rdata);
                chk("resp_fault_nf", {31'd0, resp_fault0}, {31'd0, exp_fault0});
                last_rdata = resp_rdata;
                last_fault = resp_fault;
                pending    = 1'b0;
            end
        end
    end

    // Model computes the response from the access rules, then the request runs.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat_lit, input bit has_lit,
                          input logic [31:0] lit_rdata, input logic lit_fault);
        bit          sel, mis;
        int          lat, exp_wr, sh, g;
        logic [31:0] v, mask;
        sel = (addr[31:20] == 12'h800);
        mis = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
        sh  = (size == 2'b00) ? 8 * addr[1:0] : 16 * addr[1];
        exp_rdata = 32'h0; exp_fault = 1'b0; exp_fault0 = 1'b0; exp_wr = 0;
        if (mis) begin
            lat = 1; exp_fault = 1'b1; exp_fault0 = 1'b1;
        end else if (!we) begin
            lat = 2;
            if (!sel) exp_fault = 1'b1;
            else begin
                v = model_mem[addr[9:2]] >> sh;
                if (size == 2'b00) begin
                    v = v & 32'hFF;
                    if (!uns && v[7]) v = v | 32'hFFFFFF00;
                end else if (size == 2'b01) begin
                    v = v & 32'hFFFF;
                    if (!uns && v[15]) v = v | 32'hFFFF0000;
                end else v = model_mem[addr[9:2]];
                exp_rdata = v;
            end
        end else if (size == 2'b10) begin
            lat = 2; exp_wr = 1; exp_fault = !sel;
            if (sel) model_mem[addr[9:2]] = wdata;
        end else if (!sel) begin
            lat = 2; exp_fault = 1'b1;
        end else begin
            lat = 3; exp_wr = 1;
            mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
            model_mem[addr[9:2]] = (model_mem[addr[9:2]] & ~mask) | ((wdata << sh) & mask);
        end
        chk("model_latency", lat, lat_lit);

        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);

        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        exp_maddr = {addr[31:2], 2'b00};
        wr_cnt    = 0;
        exp_at    = cyc + lat;
        pending   = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (pending && g < 20) begin @(negedge clk); g++; end
        if (pending) begin
            chk("resp_timeout", 32'd0, 32'd1);
            pending = 1'b0;
        end
        chk("write_cycles", wr_cnt, exp_wr);
        chk("mem_word", mem[addr[9:2]], model_mem[addr[9:2]]);
        if (has_lit) begin
            chk("lit_rdata", last_rdata, lit_rdata);
            chk("lit_fault", {31'd0, last_fault}, {31'd0, lit_fault});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        do_req(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h8000_0011, 32'h0000_00AA, 3, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 2, 1'b1, 32'hDEADAAEF, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h8000_0011, 32'h0, 2, 1'b1, 32'hFFFFFFAA, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h8000_0011, 32'h0, 2, 1'b1, 32'h000000AA, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h8000_0012, 32'h0, 2, 1'b1, 32'hFFFFDEAD, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h8000_0010, 32'h0, 2, 1'b1, 32'h0000AAEF, 1'b0);

        do_req(1'b1, 2'b01, 1'b0, 32'h8000_0013, 32'h0000_5555, 1, 1'b1, 32'h0, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0012, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        do_req(1'b0, 2'b11, 1'b0, 32'h8000_0010, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        chk("word_after_faults", mem[4], 32'hDEADAAEF);

        do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 2, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1111_1111, 2, 1'b1, 32'h0, 1'b1);
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_1001, 32'h0000_0022, 2, 1'b1, 32'h0, 1'b1);

        do_req(1'b1, 2'b01, 1'b0, 32'h8000_0012, 32'hFFFF_1234, 3, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 2'b10, 1'b1, 32'h8000_0010, 32'h0, 2, 1'b1, 32'h1234AAEF, 1'b0);

        // Abort a byte store while it sits in RMW_READ.
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h8000_0011; req_wdata = 32'h0000_0077;
        wr_cnt = 0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_rw", {31'd0, mem_rw}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_writes", wr_cnt, 32'd0);
        chk("rst_mid_word", mem[4], 32'h1234AAEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 2, 1'b1, 32'h1234AAEF, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
